// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX pipeline register with RAW-hazard operand forwarding.
// Captures decoded D-stage fields and drives the ALU operands, ALU opcode and store data.
//
// Ports:
//   clk, rst                     clock and synchronous active-high reset
//   StallE, FlushE               hold / bubble requests from the hazard unit
//   ValidD .. RegWriteD          decoded D-stage instruction fields
//   AluOutM, RdM, RegWriteM      MEM-stage bypass source
//   ResultW, RdW, RegWriteW      WB-stage bypass source
//   Operand1E, Operand2E         ALU operands
//   AluTypeE                     ALU opcode
//   StoreDataE                   forwarded rs2 value for stores
//   RdE, RegWriteE, ValidE       E-stage destination, write enable, valid
//
// Build option: define EX_WB_FORWARD_EN to enable bypassing from WB.
// Without it, the WB ports are ignored and the register file must
// provide write-before-read.

`ifndef ADD
`define ADD 4'b0000
`endif

module ex_operand_stage #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            StallE,
    input  logic            FlushE,
    input  logic            ValidD,
    input  logic [XLEN-1:0] RegOut1D,
    input  logic [XLEN-1:0] RegOut2D,
    input  logic [XLEN-1:0] ImmD,
    input  logic [XLEN-1:0] PCD,
    input  logic [REGW-1:0] Rs1D,
    input  logic [REGW-1:0] Rs2D,
    input  logic [REGW-1:0] RdD,
    input  logic [3:0]      AluTypeD,
    input  logic            AluSrc1D,
    input  logic            AluSrc2D,
    input  logic            RegWriteD,
    input  logic [XLEN-1:0] AluOutM,
    input  logic [REGW-1:0] RdM,
    input  logic            RegWriteM,
    input  logic [XLEN-1:0] ResultW,
    input  logic [REGW-1:0] RdW,
    input  logic            RegWriteW,
    output logic [XLEN-1:0] Operand1E,
    output logic [XLEN-1:0] Operand2E,
    output logic [3:0]      AluTypeE,
    output logic [XLEN-1:0] StoreDataE,
    output logic [REGW-1:0] RdE,
    output logic            RegWriteE,
    output logic            ValidE
);

    logic            r_v;
    logic [XLEN-1:0] r_a1;
    logic [XLEN-1:0] r_a2;
    logic [XLEN-1:0] r_imm;
    logic [XLEN-1:0] r_pc;
    logic [REGW-1:0] r_rs1;
    logic [REGW-1:0] r_rs2;
    logic [REGW-1:0] r_rd;
    logic [3:0]      r_alu;
    logic            r_src1;
    logic            r_src2;
    logic            r_regwr;

    logic            w_m1;
    logic            w_m2;
    logic            w_w1;
    logic            w_w2;
    logic [XLEN-1:0] w_fwd1;
    logic [XLEN-1:0] w_fwd2;

    // x0 is never a bypass target; its read value is already zero.
    assign w_m1 = RegWriteM && (RdM != '0) && (RdM == r_rs1);
    assign w_m2 = RegWriteM && (RdM != '0) && (RdM == r_rs2);

`ifdef EX_WB_FORWARD_EN
    assign w_w1 = RegWriteW && (RdW != '0) && (RdW == r_rs1);
    assign w_w2 = RegWriteW && (RdW != '0) && (RdW == r_rs2);
`else
    logic w_unused_wb;
    assign w_unused_wb = ^{ResultW, RdW, RegWriteW};
    assign w_w1 = 1'b0;
    assign w_w2 = 1'b0;
`endif

    // MEM holds the younger result, so it takes priority over WB.
    always_comb begin
        w_fwd1 = r_a1;
        w_fwd2 = r_a2;
        if (w_m1)      w_fwd1 = AluOutM;
        else if (w_w1) w_fwd1 = ResultW;
        if (w_m2)      w_fwd2 = AluOutM;
        else if (w_w2) w_fwd2 = ResultW;
    end

    always_ff @(posedge clk) begin
        if (rst || FlushE) begin
            r_v     <= 1'b0;
            r_a1    <= '0;
            r_a2    <= '0;
            r_imm   <= '0;
            r_pc    <= '0;
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_rd    <= '0;
            r_alu   <= `ADD;
            r_src1  <= 1'b0;
            r_src2  <= 1'b0;
            r_regwr <= 1'b0;
        end else if (StallE) begin
            // Absorb bypass values while held: the producer may retire
            // before the stall releases.
            r_a1 <= w_fwd1;
            r_a2 <= w_fwd2;
        end else begin
            r_v     <= ValidD;
            r_a1    <= RegOut1D;
            r_a2    <= RegOut2D;
            r_imm   <= ImmD;
            r_pc    <= PCD;
            r_rs1   <= Rs1D;
            r_rs2   <= Rs2D;
            r_rd    <= RdD;
            r_alu   <= AluTypeD;
            r_src1  <= AluSrc1D;
            r_src2  <= AluSrc2D;
            r_regwr <= RegWriteD;
        end
    end

    assign Operand1E  = r_src1 ? r_pc : w_fwd1;
    assign Operand2E  = r_src2 ? r_imm : w_fwd2;
    assign StoreDataE = w_fwd2;
    assign AluTypeE   = r_alu;
    assign RdE        = r_rd;
    assign RegWriteE  = r_regwr & r_v;
    assign ValidE     = r_v;

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX pipeline register plus operand-forwarding and source-select logic.
- Sits directly upstream of the ALU and drives its Operand1, Operand2 and AluType inputs.
- Captures decoded instruction fields each cycle.
- Resolves RAW hazards by bypassing results from the MEM and WB stages.
- Supports stall (hold) and flush (bubble) from the hazard unit.

Parameters:
XLEN, 32, datapath width; must match the ALU operand width.
REGW, 5, register-index width.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
StallE  input  1  hold the E-stage register contents
FlushE  input  1  load a bubble into the E stage
ValidD  input  1  D-stage instruction is valid
RegOut1D  input  XLEN  register-file rs1 read data
RegOut2D  input  XLEN  register-file rs2 read data
ImmD  input  XLEN  sign-extended immediate
PCD  input  XLEN  instruction PC
Rs1D  input  REGW  rs1 index
Rs2D  input  REGW  rs2 index
RdD  input  REGW  rd index
AluTypeD  input  4  ALU operation code
AluSrc1D  input  1  0 = rs1, 1 = PC
AluSrc2D  input  1  0 = rs2, 1 = immediate
RegWriteD  input  1  instruction writes rd
AluOutM  input  XLEN  MEM-stage result
RdM  input  REGW  MEM-stage destination index
RegWriteM  input  1  MEM-stage writes rd (already qualified by valid)
ResultW  input  XLEN  WB-stage result
RdW  input  REGW  WB-stage destination index
RegWriteW  input  1  WB-stage writes rd (already qualified by valid)
Operand1E  output  XLEN  ALU operand 1
Operand2E  output  XLEN  ALU operand 2
AluTypeE  output  4  ALU operation code
StoreDataE  output  XLEN  forwarded rs2 value for stores
RdE  output  REGW  destination index
RegWriteE  output  1  write enable, gated by ValidE
ValidE  output  1  E-stage instruction valid

Behaviour:
- Internal registers: V, A1, A2, Imm, PC, Rs1, Rs2, Rd, AluType, Src1, Src2, RegWr.
- Update priority on each clk edge: rst > FlushE > StallE > load.
- rst or FlushE:
  - V=0, RegWr=0, Rd=0, Rs1=0, Rs2=0, A1=A2=Imm=PC=0, Src1=Src2=0.
  - AluType = `ADD from the project parameter header.
- Resulting outputs after rst or FlushE: Operand1E=0, Operand2E=0, StoreDataE=0, RegWriteE=0, ValidE=0, RdE=0.
- Load (no stall, no flush): every register takes its D-stage input (ValidD, RegOut1D, RegOut2D, etc.). Latency is 1 cycle.
- StallE:
  - Indices, immediate, PC, control fields and V hold.
  - A1 is overwritten with the current forwarded rs1 value (Fwd1); A2 with Fwd2.
  - A forward source that retires during the stall is therefore not lost.
  - Holding A1/A2 unchanged is non-compliant.
- Forwarding, combinational from the registered state:
  - Fwd1 = AluOutM if RegWriteM && RdM!=0 && RdM==Rs1.
  - Else ResultW if RegWriteW && RdW!=0 && RdW==Rs1.
  - Else A1.
  - Fwd2 is identical using Rs2 and A2.
  - MEM has priority over WB.
  - x0 is never forwarded: index 0 always yields A1/A2 as read, which the register file returns as 0.
- Output selection:
  - Operand1E = Src1 ? PC : Fwd1.
  - Operand2E = Src2 ? Imm : Fwd2.
  - StoreDataE = Fwd2, regardless of Src2.
  - AluTypeE = AluType; RdE = Rd.
  - RegWriteE = RegWr & V; ValidE = V.
- Simultaneous StallE and FlushE: flush wins.
- Simultaneous rst and anything else: reset wins.
- All forwarding paths are combinational; no extra cycle of latency. Widths are exact and no arithmetic is performed here.

Optional Feature:
- Macro: EX_WB_FORWARD_EN.
- Defined: the WB forwarding path is present, as described under Behaviour.
- Undefined:
  - The ResultW/RdW/RegWriteW ports remain but are ignored.
  - Forwarding comes from MEM only.
  - The register file must provide write-before-read.
  - During StallE, A1/A2 refresh from MEM forwarding only.

Test Plan:
- Reset: rst=1 for 2 cycles with arbitrary D inputs -> ValidE=0, RegWriteE=0, Operand1E=0, Operand2E=0, AluTypeE=`ADD.
- Plain load: RegOut1D=0x10, ImmD=0xFFFFFFF0, AluSrc2D=1, ValidD=1 -> next cycle Operand1E=0x10, Operand2E=0xFFFFFFF0, ValidE=1.
- MEM/WB priority: Rs1=5; RdM=5 with AluOutM=0xAAAA; RdW=5 with ResultW=0xBBBB; both RegWrite=1 -> Operand1E=0xAAAA. Clear RegWriteM -> 0xBBBB (with EX_WB_FORWARD_EN defined) or A1 (undefined).
- x0 guard: Rs2=0, RdM=0, RegWriteM=1, AluOutM=0x1234, Src2=0 -> Operand2E=0 and StoreDataE=0.
- Stall capture:
  - E holds Rs1=3; hold StallE=1 for 2 cycles.
  - Cycle 1: RdM=3, AluOutM=0x55.
  - Cycle 2: RdM=7, RdW=9, no match.
  - Operand1E must stay 0x55 while D-input changes are ignored.
- Flush vs stall: StallE=1 and FlushE=1 together -> next cycle ValidE=0, RegWriteE=0. Then a load with RegWriteD=1, ValidD=0 -> RegWriteE=0.
